// File: rtl/rename_pkg.sv
// rtl/rename_pkg.sv - shared rename/commit types and constants
package rename_pkg;

    localparam int NUM_ARCH_REGS = 32;

    typedef logic [5:0] preg_t;
    typedef logic [4:0] areg_t;

    typedef struct packed {
        logic  valid;
        areg_t rd;
        preg_t p_rd;
        preg_t p_old_rd;
    } commit_t;

    typedef enum logic [1:0] {
        IDLE,
        WALK,
        DONE
    } recover_state_t;

    // x0 is hardwired, so a commit targeting it never touches the RAT or the pool
    function automatic logic writes_rat(commit_t c);
        return c.valid && (c.rd != '0);
    endfunction

endpackage

// File: rtl/rat_walk_mask.sv
// rtl/rat_walk_mask.sv - clears the pregs named by a slice of RAT entries from a mask
module rat_walk_mask
    import rename_pkg::*;
#(
    parameter int WPC = 8,
    parameter int NPR = 64
) (
    input  logic [WPC*$bits(preg_t)-1:0] entries,
    input  logic [NPR-1:0]               mask_in,
    output logic [NPR-1:0]               mask_out
);

    localparam int PW = $bits(preg_t);

    always_comb begin
        mask_out = mask_in;
        for (int k = 0; k < WPC; k++) begin
            mask_out[entries[k*PW +: PW]] = 1'b0;
        end
    end

endmodule

// File: rtl/commit_release.sv
// rtl/commit_release.sv - dual-width retirement: architectural RAT, preg release, flush restore walk
module commit_release
    import rename_pkg::*;
#(
    parameter int NUM_PHYSICAL_REGISTERS = 64,
    parameter int WALK_PER_CYCLE         = 8
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              commit1_valid,
    input  logic [4:0]                        commit1_rd,
    input  logic [5:0]                        commit1_p_rd,
    input  logic [5:0]                        commit1_p_old_rd,
    input  logic                              commit2_valid,
    input  logic [4:0]                        commit2_rd,
    input  logic [5:0]                        commit2_p_rd,
    input  logic [5:0]                        commit2_p_old_rd,
    output logic                              commit_ready,
    input  logic                              flush,
    output logic                              release_valid,
    output logic [NUM_PHYSICAL_REGISTERS-1:0] release_mask,
    output logic [5:0]                        arch_rat [0:31],
    output logic                              restore_valid,
    output logic [5:0]                        restore_rat [0:31],
    output logic [NUM_PHYSICAL_REGISTERS-1:0] restore_freePool
);

    localparam int    NPR      = NUM_PHYSICAL_REGISTERS;
    localparam int    PW       = $bits(preg_t);
    localparam areg_t IDX_STEP = areg_t'(WALK_PER_CYCLE);
    localparam areg_t LAST_IDX = areg_t'(NUM_ARCH_REGS - WALK_PER_CYCLE);

    commit_t        c1;
    commit_t        c2;
    logic           c1_wr;
    logic           c2_wr;
    recover_state_t state;
    recover_state_t state_next;
    logic           walk_start;
    logic           walk_step;
    logic           walk_last;
    areg_t          idx;
    logic [NPR-1:0] acc;
    logic [NPR-1:0] walk_out;
    logic [NPR-1:0] release_next;
    logic [WALK_PER_CYCLE*PW-1:0] walk_entries;
    preg_t          rat_q     [NUM_ARCH_REGS];
    preg_t          restore_q [NUM_ARCH_REGS];

    assign c1 = {commit1_valid, commit1_rd, commit1_p_rd, commit1_p_old_rd};
    assign c2 = {commit2_valid, commit2_rd, commit2_p_rd, commit2_p_old_rd};

    assign c1_wr = commit_ready && writes_rat(c1);
    assign c2_wr = commit_ready && writes_rat(c2);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A flush always wins: it restarts the walk from any state and hides a pending DONE pulse
    always_comb begin
        state_next    = state;
        commit_ready  = 1'b0;
        restore_valid = 1'b0;
        walk_start    = 1'b0;
        walk_step     = 1'b0;
        walk_last     = 1'b0;
        case (state)
            IDLE: begin
                commit_ready = 1'b1;
                if (flush) begin
                    state_next = WALK;
                    walk_start = 1'b1;
                end
            end
            WALK: begin
                if (flush) begin
                    walk_start = 1'b1;
                end else begin
                    walk_step = 1'b1;
                    if (idx == LAST_IDX) begin
                        walk_last  = 1'b1;
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                if (flush) begin
                    state_next = WALK;
                    walk_start = 1'b1;
                end else begin
                    restore_valid = 1'b1;
                    state_next    = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Younger commit2 is checked first so it wins a same-rd collision
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_ARCH_REGS; i++) begin
                rat_q[i] <= preg_t'(i);
            end
        end else begin
            for (int i = 1; i < NUM_ARCH_REGS; i++) begin
                if (c2_wr && c2.rd == areg_t'(i)) begin
                    rat_q[i] <= c2.p_rd;
                end else if (c1_wr && c1.rd == areg_t'(i)) begin
                    rat_q[i] <= c1.p_rd;
                end
            end
        end
    end

    always_comb begin
        release_next = '0;
        if (c1_wr && c1.p_old_rd != '0) begin
            release_next[c1.p_old_rd] = 1'b1;
        end
        if (c2_wr && c2.p_old_rd != '0) begin
            release_next[c2.p_old_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            release_mask <= '0;
        end else begin
            release_mask <= release_next;
        end
    end

    assign release_valid = |release_mask;

    for (genvar k = 0; k < WALK_PER_CYCLE; k++) begin : g_walk
        assign walk_entries[k*PW +: PW] = rat_q[idx + areg_t'(k)];
    end

    rat_walk_mask #(
        .WPC (WALK_PER_CYCLE),
        .NPR (NPR)
    ) u_walk (
        .entries  (walk_entries),
        .mask_in  (acc),
        .mask_out (walk_out)
    );

    // The RAT is frozen during the walk, so the restore image can be latched on the final step
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx <= '0;
            acc <= '1;
            for (int i = 0; i < NPR; i++) begin
                restore_freePool[i] <= (i >= NUM_ARCH_REGS);
            end
            for (int i = 0; i < NUM_ARCH_REGS; i++) begin
                restore_q[i] <= preg_t'(i);
            end
        end else if (walk_start) begin
            idx <= '0;
            acc <= '1;
        end else if (walk_step) begin
            idx <= idx + IDX_STEP;
            acc <= walk_out;
            if (walk_last) begin
                restore_freePool <= {walk_out[NPR-1:1], 1'b0};
                for (int i = 0; i < NUM_ARCH_REGS; i++) begin
                    restore_q[i] <= rat_q[i];
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_ARCH_REGS; i++) begin
            arch_rat[i]    = rat_q[i];
            restore_rat[i] = restore_q[i];
        end
    end

endmodule

// File: tb/tb_commit_release.sv
// tb/tb_commit_release.sv - directed self-checking bench for commit_release
module tb_commit_release;

    logic        clk;
    logic        reset;
    logic        commit1_valid;
    logic [4:0]  commit1_rd;
    logic [5:0]  commit1_p_rd;
    logic [5:0]  commit1_p_old_rd;
    logic        commit2_valid;
    logic [4:0]  commit2_rd;
    logic [5:0]  commit2_p_rd;
    logic [5:0]  commit2_p_old_rd;
    logic        commit_ready;
    logic        flush;
    logic        release_valid;
    logic [63:0] release_mask;
    logic [5:0]  arch_rat [0:31];
    logic        restore_valid;
    logic [5:0]  restore_rat [0:31];
    logic [63:0] restore_freePool;

    int n_cmp  = 0;
    int n_fail = 0;

    localparam logic [63:0] RESET_POOL = 64'hFFFF_FFFF_0000_0000;
    // arch 3->40, 7->42, 9->50, 12->51: pregs 3,7,9,12 free low; 40,42,50,51 taken high
    localparam logic [63:0] FINAL_POOL = 64'hFFF3_FAFF_0000_1288;

    commit_release dut (
        .clk              (clk),
        .reset            (reset),
        .commit1_valid    (commit1_valid),
        .commit1_rd       (commit1_rd),
        .commit1_p_rd     (commit1_p_rd),
        .commit1_p_old_rd (commit1_p_old_rd),
        .commit2_valid    (commit2_valid),
        .commit2_rd       (commit2_rd),
        .commit2_p_rd     (commit2_p_rd),
        .commit2_p_old_rd (commit2_p_old_rd),
        .commit_ready     (commit_ready),
        .flush            (flush),
        .release_valid    (release_valid),
        .release_mask     (release_mask),
        .arch_rat         (arch_rat),
        .restore_valid    (restore_valid),
        .restore_rat      (restore_rat),
        .restore_freePool (restore_freePool)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_c1(input logic [4:0] rd, input logic [5:0] prd, input logic [5:0] pold);
        commit1_valid = 1'b1; commit1_rd = rd; commit1_p_rd = prd; commit1_p_old_rd = pold;
    endtask

    task automatic set_c2(input logic [4:0] rd, input logic [5:0] prd, input logic [5:0] pold);
        commit2_valid = 1'b1; commit2_rd = rd; commit2_p_rd = prd; commit2_p_old_rd = pold;
    endtask

    task automatic clr_commits();
        commit1_valid = 1'b0; commit1_rd = '0; commit1_p_rd = '0; commit1_p_old_rd = '0;
        commit2_valid = 1'b0; commit2_rd = '0; commit2_p_rd = '0; commit2_p_old_rd = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; clr_commits();
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        #1;
        n_cmp++; if (arch_rat[5] !== 6'd5) begin n_fail++; $display("FAIL reset_arch_rat5: got %0d expected 5", arch_rat[5]); end
        n_cmp++; if (arch_rat[0] !== 6'd0) begin n_fail++; $display("FAIL reset_arch_rat0: got %0d expected 0", arch_rat[0]); end
        n_cmp++; if (commit_ready !== 1'b1) begin n_fail++; $display("FAIL reset_commit_ready: got %b expected 1", commit_ready); end
        n_cmp++; if (restore_freePool !== RESET_POOL) begin n_fail++; $display("FAIL reset_pool: got %h expected %h", restore_freePool, RESET_POOL); end
        n_cmp++; if (release_valid !== 1'b0 || release_mask !== 64'h0) begin n_fail++; $display("FAIL reset_release: got %b/%h expected 0/0", release_valid, release_mask); end
        n_cmp++; if (restore_valid !== 1'b0) begin n_fail++; $display("FAIL reset_restore_valid: got %b expected 0", restore_valid); end
        n_cmp++; if (restore_rat[9] !== 6'd9) begin n_fail++; $display("FAIL reset_restore_rat9: got %0d expected 9", restore_rat[9]); end
        @(negedge clk);
    endtask

    task automatic test_single_commit();
        set_c1(5'd3, 6'd40, 6'd3);
        @(negedge clk);
        clr_commits();
        #1;
        n_cmp++; if (release_mask !== 64'h8) begin n_fail++; $display("FAIL single_release_mask: got %h expected 8", release_mask); end
        n_cmp++; if (release_valid !== 1'b1) begin n_fail++; $display("FAIL single_release_valid: got %b expected 1", release_valid); end
        n_cmp++; if (arch_rat[3] !== 6'd40) begin n_fail++; $display("FAIL single_arch_rat3: got %0d expected 40", arch_rat[3]); end
        @(negedge clk);
    endtask

    task automatic test_dual_same_rd();
        set_c1(5'd7, 6'd41, 6'd7);
        set_c2(5'd7, 6'd42, 6'd41);
        @(negedge clk);
        clr_commits();
        #1;
        n_cmp++; if (arch_rat[7] !== 6'd42) begin n_fail++; $display("FAIL dual_arch_rat7: got %0d expected 42", arch_rat[7]); end
        n_cmp++; if (release_mask !== 64'h0000_0200_0000_0080) begin n_fail++; $display("FAIL dual_release_mask: got %h expected 0000020000000080", release_mask); end
        n_cmp++; if (arch_rat[3] !== 6'd40) begin n_fail++; $display("FAIL dual_arch_rat3_kept: got %0d expected 40", arch_rat[3]); end
        @(negedge clk);
    endtask

    task automatic test_no_release();
        set_c1(5'd0, 6'd33, 6'd12);
        set_c2(5'd9, 6'd50, 6'd0);
        @(negedge clk);
        clr_commits();
        #1;
        n_cmp++; if (release_valid !== 1'b0) begin n_fail++; $display("FAIL norel_release_valid: got %b expected 0", release_valid); end
        n_cmp++; if (release_mask !== 64'h0) begin n_fail++; $display("FAIL norel_release_mask: got %h expected 0", release_mask); end
        n_cmp++; if (arch_rat[0] !== 6'd0) begin n_fail++; $display("FAIL norel_arch_rat0: got %0d expected 0", arch_rat[0]); end
        n_cmp++; if (arch_rat[9] !== 6'd50) begin n_fail++; $display("FAIL norel_arch_rat9: got %0d expected 50", arch_rat[9]); end
        @(negedge clk);
    endtask

    task automatic test_flush_walk();
        flush = 1'b1;
        set_c1(5'd12, 6'd51, 6'd12);
        #1;
        n_cmp++; if (commit_ready !== 1'b1) begin n_fail++; $display("FAIL flush_ready_at_flush: got %b expected 1", commit_ready); end
        @(negedge clk);
        flush = 1'b0;
        for (int cyc = 1; cyc <= 6; cyc++) begin
            if (cyc <= 5) set_c1(5'd5, 6'd60, 6'd5); else clr_commits();
            #1;
            n_cmp++; if (commit_ready !== (cyc == 6)) begin n_fail++; $display("FAIL flush_ready_c%0d: got %b expected %b", cyc, commit_ready, cyc == 6); end
            n_cmp++; if (restore_valid !== (cyc == 5)) begin n_fail++; $display("FAIL flush_restore_valid_c%0d: got %b expected %b", cyc, restore_valid, cyc == 5); end
            if (cyc == 1) begin
                n_cmp++; if (release_mask !== 64'h1000 || release_valid !== 1'b1) begin n_fail++; $display("FAIL flush_release_walk1: got %b/%h expected 1/1000", release_valid, release_mask); end
                n_cmp++; if (arch_rat[12] !== 6'd51) begin n_fail++; $display("FAIL flush_arch_rat12: got %0d expected 51", arch_rat[12]); end
            end else begin
                n_cmp++; if (release_valid !== 1'b0) begin n_fail++; $display("FAIL flush_release_c%0d: got %b expected 0", cyc, release_valid); end
            end
            if (cyc == 5) begin
                n_cmp++; if (restore_freePool !== FINAL_POOL) begin n_fail++; $display("FAIL flush_pool: got %h expected %h", restore_freePool, FINAL_POOL); end
                n_cmp++; if (restore_freePool[42] !== 1'b0 || restore_freePool[40] !== 1'b0 || restore_freePool[0] !== 1'b0) begin n_fail++; $display("FAIL flush_pool_clear_bits: got %b%b%b expected 000", restore_freePool[42], restore_freePool[40], restore_freePool[0]); end
                n_cmp++; if (restore_freePool[7] !== 1'b1 || restore_freePool[3] !== 1'b1 || restore_freePool[41] !== 1'b1) begin n_fail++; $display("FAIL flush_pool_set_bits: got %b%b%b expected 111", restore_freePool[7], restore_freePool[3], restore_freePool[41]); end
                n_cmp++; if (restore_rat[7] !== 6'd42 || restore_rat[3] !== 6'd40 || restore_rat[12] !== 6'd51) begin n_fail++; $display("FAIL flush_restore_rat: got %0d/%0d/%0d expected 42/40/51", restore_rat[7], restore_rat[3], restore_rat[12]); end
            end
            @(negedge clk);
        end
        #1;
        n_cmp++; if (arch_rat[5] !== 6'd5) begin n_fail++; $display("FAIL flush_ignored_commit: got %0d expected 5", arch_rat[5]); end
        @(negedge clk);
    endtask

    task automatic test_reflush_walk();
        flush = 1'b1;
        @(negedge clk);
        for (int cyc = 1; cyc <= 8; cyc++) begin
            flush = (cyc == 2);
            if (cyc <= 7) set_c1(5'd5, 6'd60, 6'd5); else clr_commits();
            #1;
            n_cmp++; if (restore_valid !== (cyc == 7)) begin n_fail++; $display("FAIL reflush_restore_valid_c%0d: got %b expected %b", cyc, restore_valid, cyc == 7); end
            n_cmp++; if (commit_ready !== (cyc == 8)) begin n_fail++; $display("FAIL reflush_ready_c%0d: got %b expected %b", cyc, commit_ready, cyc == 8); end
            if (cyc == 7) begin
                n_cmp++; if (restore_freePool !== FINAL_POOL) begin n_fail++; $display("FAIL reflush_pool: got %h expected %h", restore_freePool, FINAL_POOL); end
            end
            @(negedge clk);
        end
        flush = 1'b0;
        #1;
        n_cmp++; if (arch_rat[5] !== 6'd5 || release_valid !== 1'b0) begin n_fail++; $display("FAIL reflush_ignored_commit: got %0d/%b expected 5/0", arch_rat[5], release_valid); end
        @(negedge clk);
    endtask

    task automatic test_flush_in_done();
        flush = 1'b1;
        @(negedge clk);
        for (int cyc = 1; cyc <= 11; cyc++) begin
            flush = (cyc == 5);
            #1;
            n_cmp++; if (restore_valid !== (cyc == 10)) begin n_fail++; $display("FAIL done_flush_restore_valid_c%0d: got %b expected %b", cyc, restore_valid, cyc == 10); end
            n_cmp++; if (commit_ready !== (cyc == 11)) begin n_fail++; $display("FAIL done_flush_ready_c%0d: got %b expected %b", cyc, commit_ready, cyc == 11); end
            @(negedge clk);
        end
        flush = 1'b0;
    endtask

    task automatic test_async_reset_mid_walk();
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        n_cmp++; if (commit_ready !== 1'b1) begin n_fail++; $display("FAIL areset_ready: got %b expected 1", commit_ready); end
        n_cmp++; if (arch_rat[3] !== 6'd3 || arch_rat[7] !== 6'd7) begin n_fail++; $display("FAIL areset_arch_rat: got %0d/%0d expected 3/7", arch_rat[3], arch_rat[7]); end
        n_cmp++; if (restore_rat[12] !== 6'd12) begin n_fail++; $display("FAIL areset_restore_rat12: got %0d expected 12", restore_rat[12]); end
        n_cmp++; if (restore_freePool !== RESET_POOL) begin n_fail++; $display("FAIL areset_pool: got %h expected %h", restore_freePool, RESET_POOL); end
        n_cmp++; if (restore_valid !== 1'b0 || release_valid !== 1'b0) begin n_fail++; $display("FAIL areset_valids: got %b/%b expected 0/0", restore_valid, release_valid); end
        @(negedge clk);
        reset = 1'b0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            #1;
            n_cmp++; if (restore_valid !== 1'b0 || commit_ready !== 1'b1) begin n_fail++; $display("FAIL areset_idle_c%0d: got %b/%b expected 0/1", cyc, restore_valid, commit_ready); end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_single_commit();
        test_dual_same_rd();
        test_no_release();
        test_flush_walk();
        test_reflush_walk();
        test_flush_in_done();
        test_async_reset_mid_walk();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
